reorder_buffer_p: RTL
=====================

REORDER_BUFFER_P -- requirements
Module: reorder_buffer_p

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of entries; power of two, 4 to 64.
REQ-002 SHALL have parameter XLEN, default 32, data width.
REQ-003 SHALL have parameter NWB, default 2, number of writeback ports.
REQ-004 SHALL derive local TW = clog2(DEPTH), the tag width.
REQ-005 clk  in  1  clock; all state updates on the rising edge.
REQ-006 rst  in  1  reset, synchronous, active-low.
REQ-007 disp_valid  in  1  dispatch request.
REQ-008 disp_ready  out  1  entry available for dispatch.
REQ-009 disp_rd  in  5  destination register.
REQ-010 disp_done  in  1  result known at dispatch (LUI, JAL class).
REQ-011 disp_value  in  XLEN  value stored at dispatch.
REQ-012 disp_tag  out  TW  tag allocated to the current dispatch (tail index).
REQ-013 src1_tag, src2_tag  in  TW each  operand tags to look up.
REQ-014 src1_ready, src2_ready  out  1 each  operand value available.
REQ-015 src1_value, src2_value  out  XLEN each  operand value.
REQ-016 wb_valid  in  NWB  writeback strobes, one per port.
REQ-017 wb_tag  in  NWB*TW  writeback tags.
REQ-018 wb_value  in  NWB*XLEN  writeback values.
REQ-019 wb_mispredict  in  NWB  writeback marks a mispredicted branch.
REQ-020 cm_valid  out  1  head entry ready to retire.
REQ-021 cm_ready  in  1  consumer accepts the retirement.
REQ-022 cm_rd  out  5  retiring destination register.
REQ-023 cm_value  out  XLEN  retiring value.
REQ-024 cm_tag  out  TW  retiring tag.
REQ-025 cm_flush  out  1  retiring entry is mispredicted.
REQ-026 count  out  TW+1  number of occupied entries.
REQ-027 empty  out  1  count == 0.

Function
REQ-028 SHALL keep per-entry state: valid, done, mispredict, rd, value; head and tail pointers of TW bits, each wrapping DEPTH-1 -> 0.
REQ-029 Dispatch: on a cycle with disp_valid && disp_ready, SHALL write the tail entry (valid=1, done=disp_done, mispredict=0) and increment tail.
REQ-030 disp_ready SHALL = (count < DEPTH) && !(cm_valid && cm_flush).
- Full case: retiring and dispatching in the same cycle does not reuse the freed slot.
REQ-031 Writeback: for each port with wb_valid set whose tag entry is valid, SHALL set done=1, value=wb_value and mispredict=wb_mispredict.
- Writeback to an invalid entry is ignored.
- Same tag on several ports: the highest port index wins.
REQ-032 cm_valid SHALL be head entry valid && done; cm_rd, cm_value, cm_tag and cm_flush SHALL be driven combinationally from the head entry.
REQ-033 Writeback latency: writeback at edge N SHALL make cm_valid visible in cycle N+1 at the earliest.
REQ-034 Retire: on cm_valid && cm_ready, SHALL clear the head entry and increment head.
- cm_rd=0 retires normally.
- When cm_valid is low, cm_ready is a don't-care.
REQ-035 Flush: on retire with cm_flush=1, SHALL at that edge clear all entries, set tail = head+1 (the new head), and set count=0.
- Any dispatch in that cycle is blocked by REQ-030.
REQ-036 count SHALL update by +dispatch -retire per cycle; simultaneous dispatch and retire leaves count unchanged.
REQ-037 Operand lookup is combinational, in priority order:
- any wb port hitting the tag this cycle -> ready=1, value = that port's value (highest index wins);
- else tag entry valid && done -> ready=1, entry value;
- else ready=0, value=0.
REQ-038 A writeback hitting the tag currently being dispatched SHALL be ignored.

Reset
REQ-039 On a rising edge with rst=0, SHALL set head=0, tail=0, count=0 and clear every valid, done and mispredict bit; reset overrides dispatch, writeback and retire in that cycle.
REQ-040 After reset: disp_ready=1, disp_tag=0, cm_valid=0, cm_flush=0, empty=1, count=0.
REQ-041 Reset asserted mid-operation SHALL discard all in-flight entries, with no retirement in that cycle.

Verification
REQ-042 Fill: DEPTH=8, dispatch 8 entries with disp_done=0 -> disp_tag 0..7, count=8, disp_ready=0; a 9th request is not accepted.
REQ-043 In-order retire: writeback tag 2 then tag 0 -> retire tag 0; cm_valid=0 while tag 1 is pending; after writeback of tag 1, tags 1 and 2 retire in consecutive cycles.
REQ-044 Wrap-around: 20 dispatch/retire pairs at full throughput -> tags 0..7,0..7,0..3; count stays 1 after the first cycle.
REQ-045 Flush: entries 3..6 in flight, tag 3 written back with wb_mispredict=1 -> cm_flush=1 in one retire beat; next cycle empty=1 and the next disp_tag=4.
REQ-046 Bypass: wb port 0 tag 5 value 0xAA and port 1 tag 5 value 0xBB in the same cycle with src1_tag=5 -> src1_ready=1, src1_value=0xBB; the stored value is 0xBB.
REQ-047 Reset mid-run: 5 entries in flight, rst=0 for one edge -> count=0, cm_valid=0, next disp_tag=0.

Source files
------------

// File: rtl/reorder_buffer_p.sv
// reorder_buffer_p: in-order retirement buffer tracking dispatched instructions until writeback.
// Latency: a writeback at edge N makes the entry retireable in cycle N+1; lookup and commit outputs are combinational.
// Backpressure: disp_ready drops when full or while a flush is retiring; cm_ready low stalls retirement.
// Ports: clk/rst (sync, active-low); disp_* allocate the tail entry and return disp_tag;
//        src1_*/src2_* look up operand tags (writeback bypass first); wb_* are NWB packed writeback ports;
//        cm_* present the head entry for retirement; count/empty report occupancy.
module reorder_buffer_p #(
   parameter int DEPTH = 8,
   parameter int XLEN  = 32,
   parameter int NWB   = 2,
   localparam int TW   = $clog2(DEPTH)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                disp_valid,
   output logic                disp_ready,
   input  logic [4:0]          disp_rd,
   input  logic                disp_done,
   input  logic [XLEN-1:0]     disp_value,
   output logic [TW-1:0]       disp_tag,
   input  logic [TW-1:0]       src1_tag,
   input  logic [TW-1:0]       src2_tag,
   output logic                src1_ready,
   output logic                src2_ready,
   output logic [XLEN-1:0]     src1_value,
   output logic [XLEN-1:0]     src2_value,
   input  logic [NWB-1:0]      wb_valid,
   input  logic [NWB*TW-1:0]   wb_tag,
   input  logic [NWB*XLEN-1:0] wb_value,
   input  logic [NWB-1:0]      wb_mispredict,
   output logic                cm_valid,
   input  logic                cm_ready,
   output logic [4:0]          cm_rd,
   output logic [XLEN-1:0]     cm_value,
   output logic [TW-1:0]       cm_tag,
   output logic                cm_flush,
   output logic [TW:0]         count,
   output logic                empty
);

   typedef struct packed {
      logic            valid;
      logic            done;
      logic            mispred;
      logic [4:0]      rd;
      logic [XLEN-1:0] value;
   } entry_t;

   entry_t          rob [DEPTH];
   logic [TW-1:0]   head;
   logic [TW-1:0]   tail;

   logic [TW-1:0]   wb_tag_a [NWB];
   logic [XLEN-1:0] wb_val_a [NWB];
   logic [NWB-1:0]  wb_hit;

   logic [TW-1:0]   src_tag_a [2];
   logic            src_rdy_a [2];
   logic [XLEN-1:0] src_val_a [2];

   logic            disp_fire;
   logic            retire;

   // Full means no dispatch even if the head retires this cycle: the freed
   // slot only becomes usable next cycle. A retiring flush also blocks dispatch
   // because the tail is about to be repositioned.
   assign disp_ready = (count < (TW+1)'(DEPTH)) && !(cm_valid && cm_flush);
   assign disp_fire  = disp_valid && disp_ready;
   assign disp_tag   = tail;

   assign cm_valid = rob[head].valid && rob[head].done;
   assign cm_rd    = rob[head].rd;
   assign cm_value = rob[head].value;
   assign cm_tag   = head;
   assign cm_flush = rob[head].mispred;
   assign retire   = cm_valid && cm_ready;

   assign empty = (count == '0);

   // Writeback ports that actually update state: the target must be in
   // flight and must not be the slot being allocated this cycle.
   always_comb begin
      for (int p = 0; p < NWB; p++) begin
         wb_tag_a[p] = wb_tag[p*TW +: TW];
         wb_val_a[p] = wb_value[p*XLEN +: XLEN];
         wb_hit[p]   = wb_valid[p] && rob[wb_tag[p*TW +: TW]].valid &&
                       !(disp_fire && (wb_tag[p*TW +: TW] == tail));
      end
   end

   // Operand lookup: same-cycle writeback bypass beats stored state; the
   // ascending port loop lets the highest-index matching port win.
   assign src_tag_a[0] = src1_tag;
   assign src_tag_a[1] = src2_tag;

   always_comb begin
      for (int s = 0; s < 2; s++) begin
         src_rdy_a[s] = 1'b0;
         src_val_a[s] = '0;
         if (rob[src_tag_a[s]].valid && rob[src_tag_a[s]].done) begin
            src_rdy_a[s] = 1'b1;
            src_val_a[s] = rob[src_tag_a[s]].value;
         end
         for (int p = 0; p < NWB; p++) begin
            if (wb_valid[p] && (wb_tag_a[p] == src_tag_a[s])) begin
               src_rdy_a[s] = 1'b1;
               src_val_a[s] = wb_val_a[p];
            end
         end
      end
   end

   assign src1_ready = src_rdy_a[0];
   assign src1_value = src_val_a[0];
   assign src2_ready = src_rdy_a[1];
   assign src2_value = src_val_a[1];

   // Later non-blocking writes take precedence: writeback, then dispatch,
   // then retire/flush clearing.
   always_ff @(posedge clk) begin
      if (!rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            rob[i].valid   <= 1'b0;
            rob[i].done    <= 1'b0;
            rob[i].mispred <= 1'b0;
         end
      end else begin
         for (int p = 0; p < NWB; p++) begin
            if (wb_hit[p]) begin
               rob[wb_tag_a[p]].done    <= 1'b1;
               rob[wb_tag_a[p]].value   <= wb_val_a[p];
               rob[wb_tag_a[p]].mispred <= wb_mispredict[p];
            end
         end

         if (disp_fire) begin
            rob[tail].valid   <= 1'b1;
            rob[tail].done    <= disp_done;
            rob[tail].mispred <= 1'b0;
            rob[tail].rd      <= disp_rd;
            rob[tail].value   <= disp_value;
            tail              <= tail + TW'(1);
         end

         if (retire) begin
            head <= head + TW'(1);
            if (cm_flush) begin
               // Everything younger than the mispredicted branch is squashed;
               // the buffer restarts empty just past it.
               tail <= head + TW'(1);
               for (int i = 0; i < DEPTH; i++) begin
                  rob[i].valid   <= 1'b0;
                  rob[i].done    <= 1'b0;
                  rob[i].mispred <= 1'b0;
               end
            end else begin
               rob[head].valid   <= 1'b0;
               rob[head].done    <= 1'b0;
               rob[head].mispred <= 1'b0;
            end
         end

         if (retire && cm_flush) begin
            count <= '0;
         end else begin
            count <= count + (TW+1)'(disp_fire) - (TW+1)'(retire);
         end
      end
   end

endmodule
